// File: rtl/mips_prog_harness.sv
// mips_prog_harness
//   Program-load and result-check controller for the MIPS32 pipeline.
//   Streams program words into processor memory with the CPU held in reset,
//   releases the CPU, waits for HLT (bounded by TIMEOUT cycles), lets the
//   pipeline drain, then reads back a table of expected words and reports
//   pass/fail together with the first mismatch.
//
// Ports
//   clk1, rst_n                 clock, synchronous active-low reset
//   start                       one-cycle pulse, begins a load (IDLE/DONE only)
//   ld_valid/ld_ready/ld_addr/ld_data/ld_last   program word stream
//   exp_valid/exp_ready/exp_addr/exp_data       expected-result table fill
//   mem_sel/mem_we/mem_addr/mem_wdata, mem_rdata   memory port (harness side)
//   cpu_rst_n, cpu_halted       processor reset / HLT retired
//   done, pass, timeout, fail_idx, fail_data, cycles   run result
module mips_prog_harness #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int NUM_CHECKS = 4,
  parameter int TIMEOUT    = 9000,
  parameter int DRAIN_CYC  = 4,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rst_n,
  input  logic              cpu_halted,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  cycles
);

  localparam int ECNT_W = $clog2(NUM_CHECKS + 1);
  localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_CHECK, S_DONE
  } state_t;

  state_t              r_state;
  logic [ECNT_W-1:0]   r_exp_cnt;
  logic                r_exp_ready;
  logic                r_ld_ready;
  logic                r_cpu_rst_n;
  logic                r_mem_sel;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_done;
  logic                r_pass;
  logic                r_timeout;
  logic [IDX_W-1:0]    r_fail_idx;
  logic [DATA_W-1:0]   r_fail_data;
  logic [CNT_W-1:0]    r_cycles;
  logic [IDX_W-1:0]    r_idx;
  logic                r_phase;   // 0: address on port, 1: read data valid
  logic [DCNT_W-1:0]   r_dcnt;

  logic [ADDR_W-1:0]   r_tbl_addr [NUM_CHECKS];
  logic [DATA_W-1:0]   r_tbl_data [NUM_CHECKS];

  logic                w_ld_hs;
  logic                w_exp_hs;
  logic [ECNT_W-1:0]   w_exp_cnt_nxt;
  logic                w_exp_room_nxt;
  logic                w_exp_room;
  logic [IDX_W-1:0]    w_idx_inc;
  logic                w_chk_last;

  assign w_ld_hs        = (r_state == S_LOAD) && r_ld_ready && ld_valid;
  assign w_exp_hs       = exp_valid && r_exp_ready;
  assign w_exp_cnt_nxt  = r_exp_cnt + ECNT_W'(w_exp_hs);
  assign w_exp_room_nxt = (w_exp_cnt_nxt < ECNT_W'(NUM_CHECKS));
  assign w_exp_room     = (r_exp_cnt < ECNT_W'(NUM_CHECKS));
  assign w_idx_inc      = r_idx + IDX_W'(1);
  assign w_chk_last     = ((ECNT_W'(r_idx) + ECNT_W'(1)) == r_exp_cnt);

  // Table contents need no reset: only entries below r_exp_cnt are ever used.
  always_ff @(posedge clk1) begin
    if (w_exp_hs) begin
      r_tbl_addr[r_exp_cnt[IDX_W-1:0]] <= exp_addr;
      r_tbl_data[r_exp_cnt[IDX_W-1:0]] <= exp_data;
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_exp_cnt   <= '0;
      r_exp_ready <= 1'b1;
      r_ld_ready  <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_mem_sel   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_data <= '0;
      r_cycles    <= '0;
      r_idx       <= '0;
      r_phase     <= 1'b0;
      r_dcnt      <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_exp_hs) r_exp_cnt <= w_exp_cnt_nxt;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_exp_ready <= w_exp_room_nxt;
          if (start) begin
            r_state     <= S_LOAD;
            r_ld_ready  <= 1'b1;
            r_exp_ready <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_idx  <= '0;
            r_fail_data <= '0;
            r_cycles    <= '0;
          end
        end
        S_LOAD: begin
          if (w_ld_hs) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= ld_addr;
            r_mem_wdata <= ld_data;
            if (ld_last) begin
              // Last write goes out in the first RUN cycle, still harness-owned.
              r_state    <= S_RUN;
              r_ld_ready <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (!r_cpu_rst_n) begin
            r_cpu_rst_n <= 1'b1;
            r_mem_sel   <= 1'b0;
          end else if (cpu_halted) begin
            // Halt takes priority over the timeout limit; cycles freezes here.
            r_state <= S_DRAIN;
            r_dcnt  <= '0;
          end else if (r_cycles == CNT_W'(TIMEOUT - 1)) begin
            r_state     <= S_DONE;
            r_timeout   <= 1'b1;
            r_pass      <= 1'b0;
            r_done      <= 1'b1;
            r_cpu_rst_n <= 1'b0;
            r_mem_sel   <= 1'b1;
            r_exp_ready <= w_exp_room;
          end else begin
            r_cycles <= r_cycles + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DCNT_W'(DRAIN_CYC - 1)) begin
            r_state     <= S_CHECK;
            r_cpu_rst_n <= 1'b0;
            r_mem_sel   <= 1'b1;
            r_idx       <= '0;
            r_phase     <= 1'b0;
            // Present entry 0 now so its read data lands in the 2nd CHECK cycle.
            r_mem_addr  <= (r_exp_cnt != '0) ? r_tbl_addr[0] : '0;
          end else begin
            r_dcnt <= r_dcnt + DCNT_W'(1);
          end
        end
        S_CHECK: begin
          if (!r_phase) begin
            if (r_exp_cnt == '0) begin
              r_state     <= S_DONE;
              r_pass      <= 1'b1;
              r_done      <= 1'b1;
              r_exp_ready <= w_exp_room;
            end else begin
              r_phase <= 1'b1;
            end
          end else if (mem_rdata != r_tbl_data[r_idx]) begin
            r_state     <= S_DONE;
            r_fail_idx  <= r_idx;
            r_fail_data <= mem_rdata;
            r_pass      <= 1'b0;
            r_done      <= 1'b1;
            r_exp_ready <= w_exp_room;
          end else if (w_chk_last) begin
            r_state     <= S_DONE;
            r_pass      <= 1'b1;
            r_done      <= 1'b1;
            r_exp_ready <= w_exp_room;
          end else begin
            r_idx      <= w_idx_inc;
            r_mem_addr <= r_tbl_addr[w_idx_inc];
            r_phase    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_ready  = r_ld_ready;
  assign exp_ready = r_exp_ready;
  assign mem_sel   = r_mem_sel;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rst_n = r_cpu_rst_n;
  assign done      = r_done;
  assign pass      = r_pass;
  assign timeout   = r_timeout;
  assign fail_idx  = r_fail_idx;
  assign fail_data = r_fail_data;
  assign cycles    = r_cycles;

endmodule

// File: tb/tb_mips_prog_harness.sv
// Testbench for mips_prog_harness: directed scenario table plus hand-written
// reset and table-fill sequences. Memory and a stub CPU are modelled here.
module tb_mips_prog_harness;
  localparam int DATA_W = 32, ADDR_W = 10, NUM_CHECKS = 4;
  localparam int TIMEOUT = 100, DRAIN_CYC = 4, CNT_W = 16, IDX_W = 2;

  logic              clk1, rst_n, start;
  logic              ld_valid, ld_ready, ld_last;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              exp_valid, exp_ready;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              mem_sel, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              cpu_rst_n, cpu_halted;
  logic              done, pass, timeout;
  logic [IDX_W-1:0]  fail_idx;
  logic [DATA_W-1:0] fail_data;
  logic [CNT_W-1:0]  cycles;

  int errors = 0;
  int checks = 0;

  mips_prog_harness #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NUM_CHECKS),
                      .TIMEOUT(TIMEOUT), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_addr(exp_addr), .exp_data(exp_data), .mem_sel(mem_sel), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_rst_n(cpu_rst_n), .cpu_halted(cpu_halted), .done(done), .pass(pass),
    .timeout(timeout), .fail_idx(fail_idx), .fail_data(fail_data), .cycles(cycles)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Synchronous memory; words 198 and 200 come from bench-controlled values.
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] v198, v200;
  always @(posedge clk1) begin
    if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr == 10'd198) ? v198 :
                 (mem_addr == 10'd200) ? v200 : mem[mem_addr];
  end

  // Stub CPU: counts cycles out of reset, holds halted from halt_at onward.
  int run_cnt = 0;
  int halt_at = 1000;
  always @(posedge clk1) run_cnt <= cpu_rst_n ? run_cnt + 1 : 0;
  assign cpu_halted = cpu_rst_n && (run_cnt >= halt_at);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          nwords;
    bit          gap;
    int          halt;
    logic [31:0] m198;
    bit          start_in_run;
    bit          e_pass;
    bit          e_to;
    int          e_fidx;
    logic [31:0] e_fdata;
    int          e_cyc;
    int          e_chk;
    int          e_drain;
    bit          e_saw200;
  } scn_t;

  task automatic run_scn(input scn_t s, input string tag);
    int w = 0, nwr = 0, first_wr = 0, last_wr = 0, last_hs = 0, rel_cyc = 0;
    int n_chk = 0, n_drain = 0, cyc = 0;
    bit hs, hs_last, rel_seen = 0, halted_seen = 0, saw200 = 0, got_done = 0;
    halt_at = s.halt;
    v198 = s.m198;
    @(negedge clk1) start = 1'b1;
    @(negedge clk1) start = 1'b0;
    chk({tag, ".ld_ready"}, ld_ready, 1);
    chk({tag, ".done_cleared"}, done, 0);
    ld_valid = 1'b1; ld_addr = '0; ld_data = 32'h1000; ld_last = (s.nwords == 1);
    while (cyc < 2000 && !got_done) begin
      hs = ld_valid && ld_ready;
      hs_last = hs && ld_last;
      @(negedge clk1);
      cyc++;
      start = 1'b0;
      if (hs) w++;
      if (hs_last) last_hs = cyc - 1;
      if (mem_sel && mem_we) begin
        chk({tag, ".wr_addr"}, mem_addr, nwr);
        chk({tag, ".wr_data"}, mem_wdata, 32'h1000 + nwr);
        if (nwr == 0) first_wr = cyc;
        last_wr = cyc;
        nwr++;
      end
      if (cpu_rst_n && !rel_seen) begin
        rel_seen = 1;
        rel_cyc = cyc;
        if (s.start_in_run) start = 1'b1;
      end
      if (cpu_rst_n && cpu_halted) n_drain++;
      if (halted_seen && !cpu_rst_n && !done) n_chk++;
      if (halted_seen && mem_sel && mem_addr == 10'd200) saw200 = 1;
      if (cpu_halted) halted_seen = 1;
      if (done) got_done = 1;
      if (w < s.nwords && !(s.gap && hs)) begin
        ld_valid = 1'b1;
        ld_addr  = ADDR_W'(w);
        ld_data  = 32'h1000 + w;
        ld_last  = (w == s.nwords - 1);
      end else begin
        ld_valid = 1'b0;
        ld_last  = 1'b0;
      end
    end
    chk({tag, ".done_reached"}, got_done, 1);
    chk({tag, ".n_writes"}, nwr, s.nwords);
    chk({tag, ".wr_span"}, last_wr - first_wr, (s.gap ? 2 : 1) * (s.nwords - 1));
    chk({tag, ".release_lat"}, rel_cyc - last_hs, 2);
    chk({tag, ".pass"}, pass, s.e_pass);
    chk({tag, ".timeout"}, timeout, s.e_to);
    chk({tag, ".fail_idx"}, fail_idx, s.e_fidx);
    chk({tag, ".fail_data"}, fail_data, s.e_fdata);
    chk({tag, ".cycles"}, cycles, s.e_cyc);
    chk({tag, ".check_cycles"}, n_chk, s.e_chk);
    chk({tag, ".drain_cycles"}, n_drain, s.e_drain);
    chk({tag, ".saw_addr200"}, saw200, s.e_saw200);
    chk({tag, ".cpu_rst_n_done"}, cpu_rst_n, 0);
    chk({tag, ".mem_sel_done"}, mem_sel, 1);
    @(negedge clk1);
    chk({tag, ".done_held"}, done, 1);
    chk({tag, ".pass_held"}, pass, s.e_pass);
  endtask

  scn_t tbl[4];
  scn_t empty_scn;

  initial begin
    //          nw gap halt m198        sir pass to fidx fdata      cyc chk drn saw200
    tbl[0] = '{9, 1'b0, 50,   32'd5040, 1'b0, 1'b1, 1'b0, 0, 32'd0,    50, 4, 5, 1'b1};
    tbl[1] = '{9, 1'b0, 50,   32'd5041, 1'b0, 1'b0, 1'b0, 0, 32'd5041, 50, 2, 5, 1'b0};
    tbl[2] = '{9, 1'b0, 1000, 32'd5040, 1'b0, 1'b0, 1'b1, 0, 32'd0,    99, 0, 0, 1'b0};
    tbl[3] = '{5, 1'b1, 10,   32'd5040, 1'b1, 1'b1, 1'b0, 0, 32'd0,    10, 4, 5, 1'b1};
    empty_scn = '{2, 1'b0, 5, 32'd0, 1'b0, 1'b1, 1'b0, 0, 32'd0, 5, 1, 5, 1'b0};

    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_addr = '0; ld_data = '0; exp_valid = 1'b0; exp_addr = '0; exp_data = '0;
    v198 = 32'd5040; v200 = 32'd7;
    repeat (3) @(negedge clk1);
    rst_n = 1'b1;
    chk("rst.cpu_rst_n", cpu_rst_n, 0);
    chk("rst.mem_sel", mem_sel, 1);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    chk("rst.timeout", timeout, 0);
    chk("rst.fail_idx", fail_idx, 0);
    chk("rst.fail_data", fail_data, 0);
    chk("rst.cycles", cycles, 0);
    chk("rst.ld_ready", ld_ready, 0);
    chk("rst.exp_ready", exp_ready, 1);

    // Fill the table to capacity: exp_ready drops after the 4th entry.
    for (int k = 0; k < NUM_CHECKS; k++) begin
      exp_valid = 1'b1; exp_addr = ADDR_W'(300 + k); exp_data = 32'(k);
      @(negedge clk1);
      if (k == NUM_CHECKS - 2) chk("fill.exp_ready_3", exp_ready, 1);
    end
    exp_valid = 1'b0;
    chk("fill.exp_ready_full", exp_ready, 0);
    rst_n = 1'b0;
    @(negedge clk1) rst_n = 1'b1;
    chk("fill.exp_ready_after_rst", exp_ready, 1);

    // Real table: {198:5040, 200:7}.
    exp_valid = 1'b1; exp_addr = 10'd198; exp_data = 32'd5040;
    @(negedge clk1);
    exp_addr = 10'd200; exp_data = 32'd7;
    @(negedge clk1);
    exp_valid = 1'b0;
    chk("tbl.exp_ready", exp_ready, 1);

    for (int i = 0; i < 4; i++) run_scn(tbl[i], $sformatf("scn%0d", i));

    // Reset in the middle of RUN.
    halt_at = 1000;
    @(negedge clk1) start = 1'b1;
    @(negedge clk1) start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_addr = ADDR_W'(k); ld_data = 32'h1000 + k; ld_last = (k == 2);
      @(negedge clk1);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int k = 0; k < 20 && !cpu_rst_n; k++) @(negedge clk1);
    chk("midrst.released", cpu_rst_n, 1);
    repeat (3) @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1) rst_n = 1'b1;
    chk("midrst.cpu_rst_n", cpu_rst_n, 0);
    chk("midrst.mem_sel", mem_sel, 1);
    chk("midrst.done", done, 0);
    chk("midrst.exp_ready", exp_ready, 1);
    chk("midrst.cycles", cycles, 0);
    @(negedge clk1);
    chk("midrst.idle_hold", cpu_rst_n, 0);

    // Empty table after reset: pass on the first CHECK cycle.
    run_scn(empty_scn, "empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
